// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INCR  = 32'd4;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [XLEN-1:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// rtl/if_fetch_unit_fifo.sv - synchronous fetch_entry_t FIFO with flush
module fetch_fifo
    import if_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are only observed while the entry is counted.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: PC, imem request/response, fetch queue, redirect (option: IF_MISALIGN_TRAP_EN)
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             ID_stall,
    input  logic             EX_redirect,
    input  logic [WIDTH-1:0] EX_target,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic [WIDTH-1:0] IF_inst,
    output logic [WIDTH-1:0] IF_pc,
    output logic             IF_valid
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic             IF_misalign
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    pc_t           pc;
    pc_t           redirect_pc;
    logic [CW-1:0] discard;
    logic [CW-1:0] infl_count;
    logic [CW-1:0] fq_count;
    logic [CW:0]   credit_used;
    fetch_entry_t  fq_head;
    fetch_entry_t  infl_head;
    fetch_entry_t  fq_push_data;
    fetch_entry_t  infl_push_data;
    logic          req_fire;
    logic          rsp_drop;
    logic          fq_push;
    logic          fq_pop;
    logic          fq_full;
    logic          fq_empty;
    logic          infl_full;
    logic          infl_empty;
    logic          unused_ok;

    // In-flight requests plus queued entries may never exceed the queue depth,
    // which is what guarantees the fetch queue has room for every response.
    assign credit_used    = {1'b0, infl_count} + {1'b0, fq_count};
    assign imem_req_valid = i_rst_n & (credit_used < (CW+1)'(FIFO_DEPTH)) & ~EX_redirect;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response is stale if it belongs to a pre-redirect request, or arrives
    // in the redirect cycle itself (the queue is being flushed anyway).
    assign rsp_drop       = (discard != '0) | EX_redirect;
    assign fq_push        = imem_rsp_valid & ~rsp_drop;
    assign fq_pop         = IF_valid & ~ID_stall & ~EX_redirect;
    assign fq_push_data   = '{pc: infl_head.pc, inst: imem_rsp_data};
    assign infl_push_data = '{pc: pc, inst: '0};

    assign IF_valid = ~fq_empty;
    assign IF_inst  = IF_valid ? fq_head.inst : NOP_INST;
    assign IF_pc    = IF_valid ? fq_head.pc   : '0;

`ifdef IF_MISALIGN_TRAP_EN
    assign redirect_pc = {EX_target[WIDTH-1:2], 2'b00};
`else
    assign redirect_pc = EX_target;
`endif

    assign unused_ok = &{1'b0, fq_full, infl_full, infl_empty, infl_head.inst};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fetch_q (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (fq_push),
        .push_data (fq_push_data),
        .pop       (fq_pop),
        .flush     (EX_redirect),
        .head      (fq_head),
        .count     (fq_count),
        .full      (fq_full),
        .empty     (fq_empty)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_inflight_q (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (req_fire),
        .push_data (infl_push_data),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .head      (infl_head),
        .count     (infl_count),
        .full      (infl_full),
        .empty     (infl_empty)
    );

    // PC advance and stale-response accounting; a redirect overrides both.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc      <= RESET_PC;
            discard <= '0;
        end else if (EX_redirect) begin
            pc      <= redirect_pc;
            discard <= infl_count - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) pc <= pc + PC_INCR;
            if (imem_rsp_valid && discard != '0) discard <= discard - 1'b1;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    // One-cycle flag after a redirect to a target that is not word aligned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) IF_misalign <= 1'b0;
        else          IF_misalign <= EX_redirect & (EX_target[1:0] != 2'b00);
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed vector bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] target = '0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
`ifdef IF_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 1;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .ID_stall       (stall),
        .EX_redirect    (redir),
        .EX_target      (target),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .IF_inst        (if_inst),
        .IF_pc          (if_pc),
        .IF_valid       (if_valid)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .IF_misalign    (if_misalign)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Instruction memory: in-order responses mem_lat cycles after acceptance.
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];
    int    mcyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            mcyc = 0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (req_valid && req_ready) pend.push_back('{req_addr, mcyc + mem_lat});
            mcyc = mcyc + 1;
            if (pend.size() > 0 && pend[0].due <= mcyc) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit rv, input logic [31:0] ra,
                              input bit iv, input logic [31:0] ipc);
        chk({tag, ".req_valid"}, {31'd0, req_valid}, {31'd0, rv});
        if (rv) chk({tag, ".req_addr"}, req_addr, ra);
        chk({tag, ".IF_valid"}, {31'd0, if_valid}, {31'd0, iv});
        chk({tag, ".IF_pc"}, if_pc, iv ? ipc : 32'd0);
        chk({tag, ".IF_inst"}, if_inst, iv ? mem_word(ipc) : NOP);
    endtask

    task automatic step(input bit s, input bit r, input logic [31:0] t);
        @(negedge clk);
        stall  = s;
        redir  = r;
        target = t;
        #1;
    endtask

    task automatic do_reset(input int lat);
        rst_n   = 1'b0;
        stall   = 1'b0;
        redir   = 1'b0;
        target  = '0;
        mem_lat = lat;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          stall;
        bit          rv;
        logic [31:0] ra;
        bit          iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 32'h00};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[6]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[7]  = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
        vecs[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        vecs[11] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        vecs[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        vecs[13] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h14};
        vecs[14] = '{1'b0, 1'b1, 32'h1C, 1'b0, 32'h00};

        // Streaming fetch with 1-cycle memory, then a 5-cycle downstream stall.
        do_reset(1);
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].stall, 1'b0, '0);
            check_outs($sformatf("stream.c%0d", i), vecs[i].rv, vecs[i].ra, vecs[i].iv, vecs[i].ipc);
        end

        // Redirect with two requests in flight (3-cycle memory): both dropped.
        do_reset(3);
        step(0, 0, '0);          check_outs("redir.c0", 1, 32'h000, 0, 0);
        step(0, 0, '0);          check_outs("redir.c1", 1, 32'h004, 0, 0);
        step(0, 1, 32'h100);     check_outs("redir.c2", 0, 0, 0, 0);
        step(0, 0, '0);          check_outs("redir.c3", 0, 0, 0, 0);
        step(0, 0, '0);          check_outs("redir.c4", 1, 32'h100, 0, 0);
        step(0, 0, '0);          check_outs("redir.c5", 1, 32'h104, 0, 0);
        step(0, 0, '0);          check_outs("redir.c6", 0, 0, 0, 0);
        step(0, 0, '0);          check_outs("redir.c7", 0, 0, 0, 0);
        step(0, 0, '0);          check_outs("redir.c8", 0, 0, 1, 32'h100);

        // Redirect coinciding with a response and a stall.
        do_reset(1);
        step(0, 0, '0);          check_outs("rsr.c0", 1, 32'h000, 0, 0);
        step(0, 0, '0);          check_outs("rsr.c1", 1, 32'h004, 0, 0);
        step(1, 1, 32'h200);     check_outs("rsr.c2", 0, 0, 1, 32'h000);
        step(0, 0, '0);          check_outs("rsr.c3", 1, 32'h200, 0, 0);
        step(0, 0, '0);          check_outs("rsr.c4", 1, 32'h204, 0, 0);
        step(0, 0, '0);          check_outs("rsr.c5", 0, 0, 1, 32'h200);

        // Asynchronous reset between clock edges, then restart at RESET_PC.
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, '0);          check_outs("restart.c0", 1, 32'h000, 0, 0);
        step(0, 0, '0);          check_outs("restart.c1", 1, 32'h004, 0, 0);
        step(0, 0, '0);          check_outs("restart.c2", 0, 0, 1, 32'h000);

`ifdef IF_MISALIGN_TRAP_EN
        do_reset(1);
        chk("misalign.reset", {31'd0, if_misalign}, 32'd0);
        step(0, 0, '0);
        step(0, 1, 32'h102);
        chk("misalign.c1", {31'd0, if_misalign}, 32'd0);
        step(0, 0, '0);
        chk("misalign.c2", {31'd0, if_misalign}, 32'd1);
        check_outs("misalign.c2", 1, 32'h100, 0, 0);
        step(0, 0, '0);
        chk("misalign.c3", {31'd0, if_misalign}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
